// File: rtl/uart_core.sv
`timescale 1ns/1ps
// Full-duplex 16x-oversampled UART; TX and RX share one tick divider but are otherwise independent.
// TX ignores tx_start while busy (no queuing); RX reports each frame with a single-cycle rx_valid.
module uart_core #(
    parameter int CLK_DIV   = 27,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 txd,
    input  logic                 rxd,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    logic [CW-1:0] div_q, div_d;
    logic          tick;

    assign tick  = (div_q == CW'(CLK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    tx_state_t            tx_state_q;
    logic [3:0]           tx_phase_q;
    logic [2:0]           tx_idx_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_q, txd_q, tx_busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_phase_q <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_shift_q <= tx_data;
                        tx_par_q   <= (PARITY == 1) ? ~^tx_data : ^tx_data;
                        txd_q      <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        tx_phase_q <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                default: begin
                    if (tick) begin
                        tx_phase_q <= tx_phase_q + 4'd1;
                        // Bit boundary: the 16th tick of the current bit drives the next bit.
                        if (tx_phase_q == 4'd15) begin
                            case (tx_state_q)
                                TX_START: begin
                                    txd_q      <= tx_shift_q[0];
                                    tx_idx_q   <= '0;
                                    tx_state_q <= TX_DATA;
                                end
                                TX_DATA: begin
                                    if (tx_idx_q == 3'(DATA_BITS - 1)) begin
                                        tx_idx_q <= '0;
                                        if (PARITY != 0) begin
                                            txd_q      <= tx_par_q;
                                            tx_state_q <= TX_PARITY;
                                        end else begin
                                            txd_q      <= 1'b1;
                                            tx_state_q <= TX_STOP;
                                        end
                                    end else begin
                                        txd_q      <= tx_shift_q[1];
                                        tx_shift_q <= tx_shift_q >> 1;
                                        tx_idx_q   <= tx_idx_q + 3'd1;
                                    end
                                end
                                TX_PARITY: begin
                                    txd_q      <= 1'b1;
                                    tx_idx_q   <= '0;
                                    tx_state_q <= TX_STOP;
                                end
                                TX_STOP: begin
                                    if (tx_idx_q == 3'(STOP_BITS - 1)) begin
                                        tx_busy_q  <= 1'b0;
                                        tx_state_q <= TX_IDLE;
                                    end else begin
                                        tx_idx_q <= tx_idx_q + 3'd1;
                                    end
                                end
                                default: tx_state_q <= TX_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign txd     = txd_q;
    assign tx_busy = tx_busy_q;

    logic [1:0]           sync_q;
    logic                 rxs;
    rx_state_t            rx_state_q;
    logic [3:0]           rx_phase_q;
    logic [2:0]           rx_idx_q;
    logic [DATA_BITS-1:0] rx_shift_q, rx_data_q;
    logic                 rx_pbit_q, rx_valid_q, rx_perr_q, rx_ferr_q, rx_par_exp;

    assign rxs        = sync_q[1];
    assign rx_par_exp = (PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_phase_q <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_pbit_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rxd};
            rx_valid_q <= 1'b0;
            if (tick && rx_state_q != RX_IDLE && rx_state_q != RX_WAIT_HIGH)
                rx_phase_q <= rx_phase_q + 4'd1;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rxs) begin
                        rx_phase_q <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    // Mid-start-bit recheck filters short low glitches.
                    if (tick && rx_phase_q == 4'd7) begin
                        rx_phase_q <= '0;
                        rx_idx_q   <= '0;
                        rx_state_q <= rxs ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (tick && rx_phase_q == 4'd15) begin
                        rx_shift_q <= {rxs, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_idx_q == 3'(DATA_BITS - 1))
                            rx_state_q <= (PARITY != 0) ? RX_PARITY : RX_STOP;
                        else
                            rx_idx_q <= rx_idx_q + 3'd1;
                    end
                end
                RX_PARITY: begin
                    if (tick && rx_phase_q == 4'd15) begin
                        rx_pbit_q  <= rxs;
                        rx_state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (tick && rx_phase_q == 4'd15) begin
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_shift_q;
                        rx_perr_q  <= (PARITY != 0) && (rx_pbit_q != rx_par_exp);
                        rx_ferr_q  <= !rxs;
                        rx_state_q <= rxs ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rxs) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLK_DIV, default 27: clk cycles per oversample tick; bit period = 16*CLK_DIV cycles; legal range >= 1.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal values 5-8.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: stop bits transmitted; legal values 1 or 2.
REQ-005 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-006 Port rst, input, 1: reset; synchronous, active-high.
REQ-007 Port tx_start, input, 1: request to send tx_data.
REQ-008 Port tx_data, input, DATA_BITS: byte to send; sampled only on acceptance.
REQ-009 Port tx_busy, output, 1: transmitter is occupied.
REQ-010 Port txd, output, 1: serial out; idle high.
REQ-011 Port rxd, input, 1: serial in; asynchronous to clk.
REQ-012 Port rx_valid, output, 1: one-cycle pulse when a frame completes.
REQ-013 Port rx_data, output, DATA_BITS: last received data; LSB first on the line.
REQ-014 Port rx_parity_err, output, 1: parity mismatch on the last frame; valid with rx_valid.
REQ-015 Port rx_frame_err, output, 1: first stop bit sampled low; valid with rx_valid.

Function
REQ-016 Tick generator SHALL be a free-running counter 0..CLK_DIV-1 that asserts tick for one cycle at CLK_DIV-1; when CLK_DIV=1, tick SHALL be asserted every cycle.
REQ-017 TX SHALL use states IDLE, START, DATA, PARITY, STOP; each bit SHALL last exactly 16 ticks.
REQ-018 TX SHALL accept tx_start only in IDLE: latch tx_data, enter START, and raise tx_busy in the next cycle; tx_start while busy SHALL be ignored, with no queuing.
REQ-019 TX SHALL send data LSB first and skip PARITY when PARITY=0.
REQ-020 TX parity bit SHALL be: odd = ~^data, even = ^data.
REQ-021 TX SHALL send STOP_BITS high bits, then return to IDLE with tx_busy low; back-to-back tx_start is accepted in the first IDLE cycle.
REQ-022 rxd SHALL pass through a 2-flop synchroniser whose flops reset to 1; RX SHALL use only the synchronised value.
REQ-023 RX SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. The RX tick phase counter SHALL be cleared on leaving IDLE.
REQ-024 IDLE -> START on synchronised low. START SHALL resample at tick 8: if high (glitch), return to IDLE without any rx_valid; if low, enter DATA.
REQ-025 DATA SHALL sample each bit 16 ticks after the previous sample (mid-bit), shift in LSB first, and leave after DATA_BITS samples; PARITY is skipped when PARITY=0.
REQ-026 STOP SHALL sample one bit only, in the same cycle it:
 - pulses rx_valid;
 - loads rx_data;
 - sets rx_parity_err and rx_frame_err for this frame.
REQ-027 After STOP: if stop bit = 1, go to IDLE; if 0, go to WAIT_HIGH, which SHALL hold until the synchronised rxd = 1 (break/line-low handling), then go to IDLE.
REQ-028 rx_data and both error flags SHALL hold their values until the next rx_valid.
REQ-029 TX and RX SHALL operate independently (full duplex); simultaneous activity SHALL not affect either path.
REQ-030 Second and further stop bits on RX SHALL be treated as idle line.

Reset
REQ-031 While rst is high, at the next edge:
 - txd = 1; tx_busy = 0; rx_valid = 0;
 - rx_data = 0; rx_parity_err = 0; rx_frame_err = 0;
 - both FSMs go to IDLE;
 - the tick counter goes to 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no rx_valid and no partial txd bits after reset.

Verification (CLK_DIV=1, bit = 16 cycles)
REQ-033 8N1, tx_start with tx_data=0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; tx_busy high for 160 cycles.
REQ-034 Loopback txd->rxd, 8E1, send 0x3C -> parity bit 0; one rx_valid, rx_data=0x3C, both error flags 0; repeat with 8O1 -> parity bit 1, flags 0.
REQ-035 8E1, drive frame 0x3C with parity bit 1 -> rx_valid, rx_data=0x3C, rx_parity_err=1, rx_frame_err=0.
REQ-036 8N1, drive 0x55 with stop bit low, then hold rxd low for 64 cycles -> rx_valid once, rx_frame_err=1; no further rx_valid until rxd goes high and a new start bit arrives.
REQ-037 rxd low for 4 cycles then high -> no rx_valid; a following valid frame 0x81 is received correctly.
REQ-038 rst pulsed mid-data on both paths -> txd=1 and tx_busy=0 next cycle, no rx_valid; a subsequent 0x42 transfer completes correctly.
